bouncing_box_engine: RTL and testbench

//   Pixel-generation stage between the VGA sync generator and the PMOD output mapping in tt_um_vga_example.

---
 rtl/vga_pkg.sv | 54 +++++
 rtl/bounce_axis.sv | 100 ++++++++++
 rtl/bouncing_box_engine.sv | 143 ++++++++++++++
 tb/tb_bouncing_box_engine.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared constants for the VGA pixel pipeline:
//   - default active-area geometry and bouncing-box motion parameters
//   - 640x480@60 sync timing constants (front porch / sync / back porch)
//   - the 4-entry box palette, packed as {R[1:0], G[1:0], B[1:0]}
//   - the direction type used by the per-axis bounce logic
// -----------------------------------------------------------------------------
package vga_pkg;

  // Visible area and default box behaviour
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int BOX_SIZE_DEF = 100;
  localparam int STEP_DEF     = 2;

  // Sync timing for 640x480@60 with a 25.175 MHz pixel clock
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOTAL = H_ACTIVE_DEF + H_FRONT + H_SYNC + H_BACK;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FRONT + V_SYNC + V_BACK;

  // Direction of travel along one axis
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  // Palette: red, green, blue, yellow
  localparam logic [5:0] PALETTE [0:3] = '{
    6'b11_00_00,
    6'b00_11_00,
    6'b00_00_11,
    6'b11_11_00
  };

  // Palette lookup; an unexpected index falls back to black
  function automatic logic [5:0] palette_colour(input logic [1:0] idx);
    logic [5:0] colour;
    case (idx)
      2'd0:    colour = PALETTE[0];
      2'd1:    colour = PALETTE[1];
      2'd2:    colour = PALETTE[2];
      2'd3:    colour = PALETTE[3];
      default: colour = 6'd0;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// -----------------------------------------------------------------------------
// bounce_axis
//   Position and direction of the box along one axis. On each tick the edge
//   moves by STEP; if the move would push the far side of the box past LIMIT
//   (or the near side below 0) the position is clamped to the edge, the
//   direction flips and hit pulses for that tick.
//
//   Parameters: LIMIT (active extent of the axis), SIZE (box edge), STEP.
//   Ports:
//     clk    in   pixel clock
//     reset  in   synchronous active-high reset (pos=0, dir=DIR_POS)
//     tick   in   advance one frame step this cycle
//     pos    out  [9:0] current near edge (registered)
//     dir    out  current direction (registered)
//     hit    out  bounce strobe, valid in the tick cycle so the owner can
//                 update its own state on the same clock edge
// -----------------------------------------------------------------------------
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT = H_ACTIVE_DEF,
  parameter int SIZE  = BOX_SIZE_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  output logic [9:0] pos,
  output dir_e       dir,
  output logic       hit
);

  // The far-edge test is done in 11 bits so pos+SIZE+STEP can never wrap
  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] REACH_W = 11'(SIZE + STEP);
  localparam logic [9:0]  MAX_POS = 10'(LIMIT - SIZE);
  localparam logic [9:0]  STEP_W  = 10'(STEP);

  logic [9:0] pos_r;
  logic [9:0] pos_nxt_s;
  dir_e       dir_r;
  dir_e       dir_nxt_s;
  logic       bounce_s;

  // Candidate position/direction for this frame and whether it bounces
  always_comb begin
    pos_nxt_s = pos_r;
    dir_nxt_s = dir_r;
    bounce_s  = 1'b0;
    case (dir_r)
      DIR_POS: begin
        if (({1'b0, pos_r} + REACH_W) > LIMIT_W) begin
          pos_nxt_s = MAX_POS;
          dir_nxt_s = DIR_NEG;
          bounce_s  = 1'b1;
        end else begin
          pos_nxt_s = pos_r + STEP_W;
          dir_nxt_s = DIR_POS;
          bounce_s  = 1'b0;
        end
      end
      DIR_NEG: begin
        if (pos_r < STEP_W) begin
          pos_nxt_s = 10'd0;
          dir_nxt_s = DIR_POS;
          bounce_s  = 1'b1;
        end else begin
          pos_nxt_s = pos_r - STEP_W;
          dir_nxt_s = DIR_NEG;
          bounce_s  = 1'b0;
        end
      end
      default: begin
        // Unreachable encoding: recover to the reset corner
        pos_nxt_s = 10'd0;
        dir_nxt_s = DIR_POS;
        bounce_s  = 1'b0;
      end
    endcase
  end

  // Position/direction register, advanced only on tick
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r <= 10'd0;
      dir_r <= DIR_POS;
    end else if (tick) begin
      pos_r <= pos_nxt_s;
      dir_r <= dir_nxt_s;
    end else begin
      pos_r <= pos_r;
      dir_r <= dir_r;
    end
  end

  assign pos = pos_r;
  assign dir = dir_r;
  assign hit = tick & bounce_s;

endmodule

// File: rtl/bouncing_box_engine.sv
// -----------------------------------------------------------------------------
// bouncing_box_engine
//   Pixel stage between the VGA sync generator and the output pin mapping.
//   A BOX_SIZE square moves STEP pixels per axis once per frame, bounces off
//   the active-area edges and takes the next palette colour on every bounce
//   (a corner bounce advances the colour once). Colour and syncs are both
//   registered so they leave the block aligned.
//
//   Ports:
//     clk, reset            pixel clock, synchronous active-high reset
//     hsync_in, vsync_in    syncs from the generator
//     display_on            high inside the visible area
//     hpos, vpos            [9:0] current pixel column / row
//     pause                 1 = hold position, direction and colour
//     hsync_out, vsync_out  syncs delayed one cycle
//     r, g, b               [1:0] registered pixel colour
//     box_x, box_y          [9:0] current top-left corner of the box
// -----------------------------------------------------------------------------
module bouncing_box_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF,
  parameter int STEP     = STEP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       pause,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [9:0]  FIRST_BLANK_LINE = 10'(V_ACTIVE);
  localparam logic [10:0] BOX_W            = 11'(BOX_SIZE);

  logic       frame_tick_s;
  logic       move_tick_s;
  logic [9:0] box_x_s;
  logic [9:0] box_y_s;
  dir_e       dir_x_s;
  dir_e       dir_y_s;
  logic [1:0] dir_unused_s;
  logic       hit_x_s;
  logic       hit_y_s;
  logic [1:0] colour_idx_r;
  logic       in_x_s;
  logic       in_y_s;
  logic [5:0] pix_s;

  // One cycle per frame, at the start of the first blanking line, so the box
  // never moves while visible pixels are being drawn. pause is only looked at
  // here, which is what makes mid-frame pause toggles harmless.
  assign frame_tick_s = (hpos == 10'd0) && (vpos == FIRST_BLANK_LINE);
  assign move_tick_s  = frame_tick_s && !pause;

  bounce_axis #(
    .LIMIT (H_ACTIVE),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP)
  ) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .tick  (move_tick_s),
    .pos   (box_x_s),
    .dir   (dir_x_s),
    .hit   (hit_x_s)
  );

  bounce_axis #(
    .LIMIT (V_ACTIVE),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP)
  ) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .tick  (move_tick_s),
    .pos   (box_y_s),
    .dir   (dir_y_s),
    .hit   (hit_y_s)
  );

  // Directions are internal to the axes; kept visible for debug probing only
  assign dir_unused_s = {dir_x_s, dir_y_s};

  // Palette index: one step per bounce frame, even when both axes bounce
  always_ff @(posedge clk) begin
    if (reset) begin
      colour_idx_r <= 2'd0;
    end else if (hit_x_s || hit_y_s) begin
      colour_idx_r <= colour_idx_r + 2'd1;
    end else begin
      colour_idx_r <= colour_idx_r;
    end
  end

  // Box coverage test, widened to 11 bits so box+BOX_SIZE cannot wrap
  assign in_x_s = ({1'b0, hpos} >= {1'b0, box_x_s}) &&
                  ({1'b0, hpos} <  ({1'b0, box_x_s} + BOX_W));
  assign in_y_s = ({1'b0, vpos} >= {1'b0, box_y_s}) &&
                  ({1'b0, vpos} <  ({1'b0, box_y_s} + BOX_W));

  // Colour for the pixel currently presented; black outside the visible area
  always_comb begin
    pix_s = 6'd0;
    if (display_on && in_x_s && in_y_s) begin
      pix_s = palette_colour(colour_idx_r);
    end else begin
      pix_s = 6'd0;
    end
  end

  // Output stage: colour and syncs share one register so they stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      r         <= 2'd0;
      g         <= 2'd0;
      b         <= 2'd0;
    end else begin
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      r         <= pix_s[5:4];
      g         <= pix_s[3:2];
      b         <= pix_s[1:0];
    end
  end

  assign box_x = box_x_s;
  assign box_y = box_y_s;

endmodule

// File: tb/tb_bouncing_box_engine.sv
// -----------------------------------------------------------------------------
// tb_bouncing_box_engine
//   Two instances: the default 640x480 geometry, and a small 64x48 field with
//   a 16-pixel box where x and y bounces coincide (corner hit) after a few
//   hundred frames. Frame ticks are driven directly (hpos=0, vpos=V_ACTIVE),
//   so a "frame" costs a single clock. A reference model per instance keeps
//   the box as plain integers and applies the motion rules frame by frame.
// -----------------------------------------------------------------------------
module tb_bouncing_box_engine;

  localparam int HA [2] = '{640, 64};
  localparam int VA [2] = '{480, 48};
  localparam int BS [2] = '{100, 16};
  localparam int ST [2] = '{2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i [2];
  logic       hs_i    [2];
  logic       vs_i    [2];
  logic       don_i   [2];
  logic       pause_i [2];
  logic [9:0] hpos_i  [2];
  logic [9:0] vpos_i  [2];
  logic       hs_o    [2];
  logic       vs_o    [2];
  logic [1:0] r_o     [2];
  logic [1:0] g_o     [2];
  logic [1:0] b_o     [2];
  logic [9:0] bx_o    [2];
  logic [9:0] by_o    [2];

  bouncing_box_engine u_dut0 (
    .clk        (clk),
    .reset      (reset_i[0]),
    .hsync_in   (hs_i[0]),
    .vsync_in   (vs_i[0]),
    .display_on (don_i[0]),
    .hpos       (hpos_i[0]),
    .vpos       (vpos_i[0]),
    .pause      (pause_i[0]),
    .hsync_out  (hs_o[0]),
    .vsync_out  (vs_o[0]),
    .r          (r_o[0]),
    .g          (g_o[0]),
    .b          (b_o[0]),
    .box_x      (bx_o[0]),
    .box_y      (by_o[0])
  );

  bouncing_box_engine #(
    .H_ACTIVE (64),
    .V_ACTIVE (48),
    .BOX_SIZE (16),
    .STEP     (2)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset_i[1]),
    .hsync_in   (hs_i[1]),
    .vsync_in   (vs_i[1]),
    .display_on (don_i[1]),
    .hpos       (hpos_i[1]),
    .vpos       (vpos_i[1]),
    .pause      (pause_i[1]),
    .hsync_out  (hs_o[1]),
    .vsync_out  (vs_o[1]),
    .r          (r_o[1]),
    .g          (g_o[1]),
    .b          (b_o[1]),
    .box_x      (bx_o[1]),
    .box_y      (by_o[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: position, direction (+1/-1) and palette index
  int mx [2];
  int my [2];
  int mdx [2];
  int mdy [2];
  int mcol [2];

  int exp_hs [2];
  int exp_vs [2];
  int exp_rgb [2];
  bit exp_blank [2];

  bit probe_pend [2];
  bit probe_chk [2];
  bit probe_corner [2];
  int probe_col [2];
  bit edge_chk [2];
  int edge_exp [2];
  bit corner_seen [2];
  bit rb_seen [2];
  bit lb_seen [2];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pal(input int c);
    case (c)
      0:       return 'b110000;
      1:       return 'b001100;
      2:       return 'b000011;
      default: return 'b111100;
    endcase
  endfunction

  // One frame of motion on one axis
  task automatic axis_step(inout int p, inout int d, input int lim, input int size,
                           input int st, output bit hit);
    hit = 1'b0;
    if (d > 0) begin
      if (p + size + st > lim) begin
        p = lim - size;
        d = -1;
        hit = 1'b1;
      end else begin
        p = p + st;
      end
    end else begin
      if (p < st) begin
        p = 0;
        d = 1;
        hit = 1'b1;
      end else begin
        p = p - st;
      end
    end
  endtask

  // Expected outputs after the coming edge, then advance the model
  task automatic model_cycle(input int i);
    bit hx;
    bit hy;
    int hp;
    int vp;
    int dx_before;
    hp = int'(hpos_i[i]);
    vp = int'(vpos_i[i]);
    exp_blank[i] = !don_i[i];
    if (reset_i[i]) begin
      exp_hs[i] = 0;
      exp_vs[i] = 0;
      exp_rgb[i] = 0;
      mx[i] = 0;
      my[i] = 0;
      mdx[i] = 1;
      mdy[i] = 1;
      mcol[i] = 0;
    end else begin
      exp_hs[i] = int'(hs_i[i]);
      exp_vs[i] = int'(vs_i[i]);
      if (don_i[i] && hp >= mx[i] && hp < mx[i] + BS[i] && vp >= my[i] && vp < my[i] + BS[i])
        exp_rgb[i] = pal(mcol[i]);
      else
        exp_rgb[i] = 0;
      if (hp == 0 && vp == VA[i] && !pause_i[i]) begin
        dx_before = mdx[i];
        axis_step(mx[i], mdx[i], HA[i], BS[i], ST[i], hx);
        axis_step(my[i], mdy[i], VA[i], BS[i], ST[i], hy);
        if (hx || hy) begin
          probe_col[i] = pal((mcol[i] + 1) % 4);
          mcol[i] = (mcol[i] + 1) % 4;
          probe_pend[i] = 1'b1;
          probe_corner[i] = hx && hy;
          if (hx && hy) corner_seen[i] = 1'b1;
        end
        if (hx) begin
          edge_chk[i] = 1'b1;
          if (dx_before > 0) begin
            edge_exp[i] = HA[i] - BS[i];
            rb_seen[i] = 1'b1;
          end else begin
            edge_exp[i] = 0;
            lb_seen[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic drive(input int i, input bit rst, input int hp, input int vp,
                       input bit don, input bit pz);
    reset_i[i] = rst;
    hpos_i[i] = 10'(hp);
    vpos_i[i] = 10'(vp);
    don_i[i] = don;
    pause_i[i] = pz;
    hs_i[i] = 1'($urandom_range(0, 1));
    vs_i[i] = 1'($urandom_range(0, 1));
    probe_pend[i] = 1'b0;
  endtask

  task automatic gen_random(input int i);
    int t;
    int mode;
    hs_i[i] = 1'($urandom_range(0, 1));
    vs_i[i] = 1'($urandom_range(0, 1));
    reset_i[i] = ($urandom_range(0, 3999) == 0);
    pause_i[i] = ($urandom_range(0, 7) == 0);
    if (probe_pend[i]) begin
      // Look at the box's new top-left pixel right after a bounce
      probe_pend[i] = 1'b0;
      probe_chk[i] = 1'b1;
      reset_i[i] = 1'b0;
      don_i[i] = 1'b1;
      hpos_i[i] = 10'(mx[i]);
      vpos_i[i] = 10'(my[i]);
    end else begin
      mode = $urandom_range(0, 3);
      if (mode < 2) begin
        hpos_i[i] = 10'd0;
        vpos_i[i] = 10'(VA[i]);
        don_i[i] = 1'b0;
      end else if (mode == 2) begin
        t = mx[i] + $urandom_range(0, BS[i] + 3) - 2;
        if (t < 0) t = 0;
        if (t > 1023) t = 1023;
        hpos_i[i] = 10'(t);
        t = my[i] + $urandom_range(0, BS[i] + 3) - 2;
        if (t < 0) t = 0;
        if (t > 1023) t = 1023;
        vpos_i[i] = 10'(t);
        don_i[i] = ($urandom_range(0, 3) != 0);
      end else begin
        hpos_i[i] = 10'($urandom_range(0, 1023));
        vpos_i[i] = 10'($urandom_range(0, 1023));
        don_i[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Model, clock edge, then compare every output of both instances
  task automatic cycle();
    string tag;
    int rgb;
    for (int i = 0; i < 2; i++) model_cycle(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rgb = int'({r_o[i], g_o[i], b_o[i]});
      check_eq($sformatf("hsync_out%0d", i), int'(hs_o[i]), exp_hs[i]);
      check_eq($sformatf("vsync_out%0d", i), int'(vs_o[i]), exp_vs[i]);
      check_eq($sformatf("rgb%0d", i), rgb, exp_rgb[i]);
      check_eq($sformatf("box_x%0d", i), int'(bx_o[i]), mx[i]);
      check_eq($sformatf("box_y%0d", i), int'(by_o[i]), my[i]);
      if (exp_blank[i]) check_eq($sformatf("rgb_blank%0d", i), rgb, 0);
      if (probe_chk[i]) begin
        if (probe_corner[i]) tag = $sformatf("corner_colour%0d", i);
        else tag = $sformatf("bounce_colour%0d", i);
        check_eq(tag, rgb, probe_col[i]);
        probe_chk[i] = 1'b0;
      end
      if (edge_chk[i]) begin
        check_eq($sformatf("edge_box_x%0d", i), int'(bx_o[i]), edge_exp[i]);
        edge_chk[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int cyc;
    bit done;
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 1; mdy[i] = 1; mcol[i] = 0;
      probe_pend[i] = 1'b0; probe_chk[i] = 1'b0; edge_chk[i] = 1'b0;
      corner_seen[i] = 1'b0; rb_seen[i] = 1'b0; lb_seen[i] = 1'b0;
    end

    // Reset both instances
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 5, 5, 1'b1, 1'b0);
      drive(1, 1'b1, 5, 5, 1'b1, 1'b0);
      cycle();
    end
    check_eq("rst_box_x", int'(bx_o[0]), 0);
    check_eq("rst_box_y", int'(by_o[0]), 0);
    check_eq("rst_rgb", int'({r_o[0], g_o[0], b_o[0]}), 0);
    check_eq("rst_hsync", int'(hs_o[0]), 0);

    // First frame tick moves the box to (2,2), colour stays red
    drive(0, 1'b0, 0, 480, 1'b0, 1'b0); gen_random(1); cycle();
    check_eq("t1_box_x", int'(bx_o[0]), 2);
    check_eq("t1_box_y", int'(by_o[0]), 2);
    drive(0, 1'b0, 2, 2, 1'b1, 1'b0); gen_random(1); cycle();
    check_eq("t1_red", int'({r_o[0], g_o[0], b_o[0]}), 'b110000);
    drive(0, 1'b0, 1, 2, 1'b1, 1'b0); gen_random(1); cycle();
    check_eq("t1_black", int'({r_o[0], g_o[0], b_o[0]}), 0);

    // Pause across three frames, releasing pause between ticks
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b0, 0, 480, 1'b0, 1'b1); gen_random(1); cycle();
      drive(0, 1'b0, 7, 7, 1'b0, 1'b0); gen_random(1); cycle();
    end
    check_eq("pause_box_x", int'(bx_o[0]), 2);
    check_eq("pause_box_y", int'(by_o[0]), 2);
    drive(0, 1'b0, 2, 2, 1'b1, 1'b1); gen_random(1); cycle();
    check_eq("pause_colour", int'({r_o[0], g_o[0], b_o[0]}), 'b110000);
    drive(0, 1'b0, 0, 480, 1'b0, 1'b0); gen_random(1); cycle();
    check_eq("resume_box_x", int'(bx_o[0]), 4);
    check_eq("resume_box_y", int'(by_o[0]), 4);

    // Reset in the middle of a frame, then the next tick moves again
    drive(0, 1'b1, 100, 100, 1'b1, 1'b0); gen_random(1); cycle();
    check_eq("midrst_box_x", int'(bx_o[0]), 0);
    drive(0, 1'b0, 0, 480, 1'b0, 1'b0); gen_random(1); cycle();
    check_eq("midrst_tick_x", int'(bx_o[0]), 2);
    check_eq("midrst_tick_y", int'(by_o[0]), 2);

    // Random stream until both edges of the big field and a corner were hit
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 30000) begin
      gen_random(0);
      gen_random(1);
      cycle();
      cyc++;
      done = corner_seen[1] && rb_seen[0] && lb_seen[0];
    end
    check_eq("bounce_events_reached", int'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
